// File: rtl/usr_seq_pkg.sv
// usr_seq_pkg: shared encodings for the shift-register command sequencer.
// Op codes match the ctrl[1:0] input of the 4-bit universal shift register.
package usr_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_ROTR = 2'b01,
        OP_ROTL = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int DEF_CNT_W = 8;
    localparam int ENTRY_W   = 2 + 4 + DEF_CNT_W;

    // Entry layout is {op, data, repeat}
    function automatic int entry_width(input int cnt_w);
        return 2 + 4 + cnt_w;
    endfunction

endpackage

// File: rtl/usr_seq_fifo.sv
// usr_seq_fifo: synchronous command FIFO with flush and recirculation.
// Level is a separate counter; full/empty are derived from it only.
module usr_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 14,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; the head is read before it can be overwritten
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointer and level bookkeeping; flush wins over push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// usr_cmd_sequencer: plays queued {op,data,repeat} commands into the shift register.
// Optional USR_SEQ_LOOP_EN adds a loop input that replays the queue indefinitely.
module usr_cmd_sequencer
    import usr_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [3:0]               cmd_data,
    input  logic [CNT_W-1:0]         cmd_rpt,
    input  logic                     start,
    input  logic                     abort,
`ifdef USR_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    output logic [1:0]               ctrl,
    output logic [3:0]               d,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int EW = entry_width(CNT_W);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    state_e           state;
    logic [CNT_W-1:0] cur_cnt;
    logic [EW-1:0]    head;
    logic [EW-1:0]    fifo_din;
    logic             empty;
    logic             full;
    logic             pop;
    logic             ext_push;
    logic             recirc;
    logic             fifo_push;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);

    // Head leaves on start from IDLE or on the last hold cycle in EXEC
    assign pop = !abort && !empty &&
                 ((state == ST_IDLE && start) ||
                  (state == ST_EXEC && cur_cnt == '0));

`ifdef USR_SEQ_LOOP_EN
    // Looping rewrites each popped entry at the tail; the start cycle
    // is blocked too so its recirculating pop never meets a host push
    assign recirc    = pop && loop;
    assign cmd_ready = !full && !(loop && (busy || start));
`else
    assign recirc    = 1'b0;
    assign cmd_ready = !full;
`endif

    assign ext_push  = cmd_valid && cmd_ready && !abort;
    assign fifo_push = ext_push || recirc;
    assign fifo_din  = recirc ? head : {cmd_op, cmd_data, cmd_rpt};

    usr_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .flush (abort),
        .din   (fifo_din),
        .dout  (head),
        .level (level)
    );

    // Playback FSM with registered shift-register drive and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cur_cnt <= '0;
            ctrl    <= OP_HOLD;
            d       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            cur_cnt <= '0;
            ctrl    <= OP_HOLD;
            d       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (pop) begin
                        ctrl    <= head[EW-1 -: 2];
                        d       <= head[CNT_W+3 : CNT_W];
                        cur_cnt <= head[CNT_W-1:0];
                        busy    <= 1'b1;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cur_cnt != '0) begin
                        cur_cnt <= cur_cnt - 1'b1;
                    end else if (pop) begin
                        ctrl    <= head[EW-1 -: 2];
                        d       <= head[CNT_W+3 : CNT_W];
                        cur_cnt <= head[CNT_W-1:0];
                    end else begin
                        ctrl  <= OP_HOLD;
                        d     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ctrl  <= OP_HOLD;
                    d     <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// tb_usr_cmd_sequencer: directed checks of the command sequencer,
// including a model of the attached 4-bit universal shift register.
module tb_usr_cmd_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [7:0] cmd_rpt = 8'h00;
    logic       start = 1'b0;
    logic       abort = 1'b0;
`ifdef USR_SEQ_LOOP_EN
    logic       loop = 1'b0;
`endif
    logic [1:0] ctrl;
    logic [3:0] d;
    logic       busy;
    logic       done;
    logic [3:0] level;

    logic [3:0] q = 4'h0;
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int base;

    usr_cmd_sequencer #(.DEPTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_rpt   (cmd_rpt),
        .start     (start),
        .abort     (abort),
`ifdef USR_SEQ_LOOP_EN
        .loop      (loop),
`endif
        .ctrl      (ctrl),
        .d         (d),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Reference shift register fed by the sequencer outputs
    always @(posedge clk) begin
        case (ctrl)
            2'b11: q <= d;
            2'b10: q <= {q[2:0], q[3]};
            2'b01: q <= {q[0], q[3:1]};
            default: q <= q;
        endcase
    end

    // Count done pulses, sampled mid-cycle
    always @(negedge clk) begin
        #1;
        if (done === 1'b1)
            done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] dat,
                        input logic [7:0] rpt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = dat;
        cmd_rpt   = rpt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ctrl", 32'(ctrl), 32'h0);
        check("rst_d", 32'(d), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_level", 32'(level), 32'h0);
        reset = 1'b0;
        tick();

        // LOAD A then ROTL x3: q reads A,5,A,5
        push(2'b11, 4'hA, 8'd0);
        push(2'b10, 4'h0, 8'd2);
        check("t2_level", 32'(level), 32'h2);
        base = done_cnt;
        do_start();
        check("t2_c0", 32'(ctrl), 32'h3);
        check("t2_d0", 32'(d), 32'hA);
        check("t2_busy", 32'(busy), 32'h1);
        tick();
        check("t2_c1", 32'(ctrl), 32'h2);
        check("t2_q1", 32'(q), 32'hA);
        tick();
        check("t2_c2", 32'(ctrl), 32'h2);
        check("t2_q2", 32'(q), 32'h5);
        tick();
        check("t2_c3", 32'(ctrl), 32'h2);
        check("t2_q3", 32'(q), 32'hA);
        tick();
        check("t2_done", 32'(done), 32'h1);
        check("t2_ctrl_hold", 32'(ctrl), 32'h0);
        check("t2_busy_off", 32'(busy), 32'h0);
        check("t2_q4", 32'(q), 32'h5);
        tick();
        check("t2_done_off", 32'(done), 32'h0);
        tick();
        check("t2_done_cnt", 32'(done_cnt - base), 32'h1);

        // Fill to DEPTH, ninth push dropped
        for (int i = 0; i < 8; i++)
            push(2'b11, 4'(i), 8'd0);
        check("t3_full_level", 32'(level), 32'h8);
        check("t3_full_ready", 32'(cmd_ready), 32'h0);
        push(2'b01, 4'hF, 8'd0);
        check("t3_drop_level", 32'(level), 32'h8);
        base = done_cnt;
        do_start();
        check("t3_pop_ready", 32'(cmd_ready), 32'h1);
        check("t3_pop_level", 32'(level), 32'h7);
        check("t3_d0", 32'(d), 32'h0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("t3_d", 32'(d), 32'(i));
            check("t3_c", 32'(ctrl), 32'h3);
        end
        tick();
        check("t3_done", 32'(done), 32'h1);
        check("t3_ctrl", 32'(ctrl), 32'h0);
        tick();
        tick();
        check("t3_done_cnt", 32'(done_cnt - base), 32'h1);
        check("t3_empty", 32'(level), 32'h0);

        // Start on empty FIFO is ignored
        base = done_cnt;
        do_start();
        check("t4_idle_ctrl", 32'(ctrl), 32'h0);
        check("t4_idle_busy", 32'(busy), 32'h0);
        tick();
        tick();
        check("t4_no_done", 32'(done_cnt - base), 32'h0);

        // Push during EXEC plays back-to-back
        push(2'b11, 4'h6, 8'd2);
        do_start();
        check("t4_c0", 32'(ctrl), 32'h3);
        check("t4_d0", 32'(d), 32'h6);
        push(2'b01, 4'h0, 8'd0);
        check("t4_lvl", 32'(level), 32'h1);
        check("t4_c1", 32'(ctrl), 32'h3);
        tick();
        check("t4_c2", 32'(ctrl), 32'h3);
        tick();
        check("t4_b2b", 32'(ctrl), 32'h1);
        check("t4_b2b_busy", 32'(busy), 32'h1);
        tick();
        check("t4_done", 32'(done), 32'h1);

        // Abort in 2nd cycle of ROTL x6 with 3 queued
        tick();
        push(2'b10, 4'h0, 8'd5);
        push(2'b11, 4'h1, 8'd0);
        push(2'b11, 4'h2, 8'd0);
        push(2'b11, 4'h3, 8'd0);
        base = done_cnt;
        do_start();
        check("t5_c0", 32'(ctrl), 32'h2);
        check("t5_lvl", 32'(level), 32'h3);
        tick();
        abort = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_data = 4'h9;
        tick();
        abort = 1'b0;
        cmd_valid = 1'b0;
        check("t5_ctrl", 32'(ctrl), 32'h0);
        check("t5_level", 32'(level), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_d", 32'(d), 32'h0);
        tick();
        tick();
        check("t5_no_done", 32'(done_cnt - base), 32'h0);
        check("t5_level2", 32'(level), 32'h0);

        // Async reset mid-EXEC
        push(2'b11, 4'h9, 8'd3);
        base = done_cnt;
        do_start();
        check("t1_exec", 32'(busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("t1_ctrl", 32'(ctrl), 32'h0);
        check("t1_d", 32'(d), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_level", 32'(level), 32'h0);
        check("t1_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("t1_no_done", 32'(done_cnt - base), 32'h0);

`ifdef USR_SEQ_LOOP_EN
        // Looping replays the queue until loop drops
        push(2'b11, 4'h1, 8'd0);
        push(2'b10, 4'h0, 8'd0);
        loop = 1'b1;
        base = done_cnt;
        do_start();
        for (int i = 0; i < 12; i++) begin
            check("t6_ctrl", 32'(ctrl), (i % 2 == 0) ? 32'h3 : 32'h2);
            check("t6_level", 32'(level), 32'h2);
            check("t6_ready", 32'(cmd_ready), 32'h0);
            tick();
        end
        loop = 1'b0;
        begin
            int n;
            n = 0;
            while (done !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            check("t6_drain_bound", 32'(n < 10), 32'h1);
        end
        tick();
        tick();
        check("t6_done_cnt", 32'(done_cnt - base), 32'h1);
        check("t6_level_end", 32'(level), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
